// File: rtl/md_unit_param.sv
// rtl/md_unit_param.sv - parametrised multiply/divide unit with architectural HI/LO
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MD_MADD_EN.
module md_unit_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             req,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DIV_CYCLES = WIDTH + 1;
  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, d_q, q_q, r_q;
  logic               is_mul, is_div, accept, wb;
  logic [WIDTH-1:0]   abs_rs, abs_rt;
  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
  logic [WIDTH:0]     rr, diff;
  logic               div_signed;
  logic [WIDTH-1:0]   div_lo, div_hi;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MD_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
  end

  assign start = !req && (is_mul || is_div);
  assign busy  = (state != IDLE);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    wb      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_n = is_div ? DIV : MUL;
      end
      MUL, DIV: if (cnt == CW'(1)) begin
        wb      = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Divider works on magnitudes; signs are restored in the final cycle.
  assign abs_rs = ((op == OP_DIV) && rs[WIDTH-1]) ? -rs : rs;
  assign abs_rt = ((op == OP_DIV) && rt[WIDTH-1]) ? -rt : rt;

  always_comb begin
    mul_signed = (op_q == OP_MULT);
`ifdef MD_MADD_EN
    mul_signed = mul_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    ext_a   = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b   = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = ext_a * ext_b;
    mul_res = prod;
`ifdef MD_MADD_EN
    if ((op_q == OP_MADD) || (op_q == OP_MADDU))
      mul_res = {hi, lo} + prod;
    else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
      mul_res = {hi, lo} - prod;
`endif
  end

  assign rr   = {r_q, q_q[WIDTH-1]};
  assign diff = rr - {1'b0, d_q};

  always_comb begin
    div_signed = (op_q == OP_DIV);
    div_lo     = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -q_q : q_q;
    div_hi     = (div_signed && a_q[WIDTH-1]) ? -r_q : r_q;
    if (b_q == '0) begin
      div_lo = '1;
      div_hi = a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      d_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
    end else begin
      state <= state_n;
      done  <= wb;
      if (accept) begin
        op_q <= op;
        a_q  <= rs;
        b_q  <= rt;
        q_q  <= abs_rs;
        d_q  <= abs_rt;
        r_q  <= '0;
        cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        // One restoring step per cycle until the sign-fixup cycle.
        if ((state == DIV) && (cnt != CW'(1))) begin
          if (!diff[WIDTH]) begin
            r_q <= diff[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_q <= rr[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      if (wb) begin
        if (state == MUL)
          {hi, lo} <= mul_res;
        else
          {hi, lo} <= {div_hi, div_lo};
      end else if ((state == IDLE) && !req) begin
        if (op == OP_MTLO) lo <= rs;
        if (op == OP_MTHI) hi <= rs;
      end
    end
  end

endmodule
